// File: rtl/bsg_round_robin_2_to_2_deswizzle_pkg.sv
// Shared types and helpers for the two-lane round-robin deswizzle.
//   lane_sel_t  : selects one of the two lane FIFOs
//   lane0/lane1 : lane index constants
//   ptr_width() : pointer width for an els-entry lane FIFO, never below 1
package bsg_round_robin_2_to_2_deswizzle_pkg;

  typedef logic lane_sel_t;

  localparam lane_sel_t lane0 = 1'b0;
  localparam lane_sel_t lane1 = 1'b1;

  localparam int num_lanes_gp = 2;

  function automatic int ptr_width(input int els);
    return (els <= 2) ? 1 : $clog2(els);
  endfunction

endpackage

// File: rtl/bsg_round_robin_2_to_2_deswizzle_lane.sv
// Single lane FIFO of els_p entries.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   data_i/v_i/ready_o : ready/valid write port
//   data_o/v_o/yumi_i  : valid/yumi read port (yumi only honoured when v_o)
// Full/empty come from equal pointers plus a wrap bit per pointer, so any
// els_p works, not just powers of two.
module bsg_round_robin_lane_fifo
  import bsg_round_robin_2_to_2_deswizzle_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = ptr_width(els_p);
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [ptr_w_lp-1:0] one_lp  = ptr_w_lp'(1);

  logic [els_p-1:0][width_p-1:0] mem_r;
  logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
  logic                rd_wrap_r, wr_wrap_r;
  logic                ptr_eq, full, empty, enq, deq;

  assign ptr_eq = (rd_ptr_r == wr_ptr_r);
  assign full   = ptr_eq & (rd_wrap_r != wr_wrap_r);
  assign empty  = ptr_eq & (rd_wrap_r == wr_wrap_r);

  // Gating with reset keeps both handshakes quiet while reset is held,
  // including the cycle before the first reset edge has cleared state.
  assign ready_o = reset_n_i & ~full;
  assign v_o     = reset_n_i & ~empty;
  assign data_o  = mem_r[rd_ptr_r];

  // Writes while full and pops while empty are ignored here, so illegal
  // traffic cannot corrupt the pointers.
  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_ptr_r  <= '0;
      wr_ptr_r  <= '0;
      rd_wrap_r <= 1'b0;
      wr_wrap_r <= 1'b0;
    end else begin
      if (enq) begin
        if (wr_ptr_r == last_lp) begin
          wr_ptr_r  <= '0;
          wr_wrap_r <= ~wr_wrap_r;
        end else begin
          wr_ptr_r  <= wr_ptr_r + one_lp;
        end
      end
      if (deq) begin
        if (rd_ptr_r == last_lp) begin
          rd_ptr_r  <= '0;
          rd_wrap_r <= ~rd_wrap_r;
        end else begin
          rd_ptr_r  <= rd_ptr_r + one_lp;
        end
      end
    end
  end

endmodule

// File: rtl/bsg_round_robin_2_to_2_deswizzle.sv
// Receive side of a round-robin FIFO pair: two lane FIFOs read back in the
// writer's global order, up to two elements per cycle.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   data_i, v_i      : per-lane write data/valid (lane k at [k*width_p +: width_p])
//   ready_o          : per-lane not-full
//   data_o, v_o      : in-order output, slot 0 oldest, v_o thermometer coded
//   yumi_i           : thermometer consume count (01 = one, 11 = two)
// tail_r names the lane holding the oldest element.
module bsg_round_robin_2_to_2_deswizzle
  import bsg_round_robin_2_to_2_deswizzle_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [2*width_p-1:0] data_i,
  input  logic [1:0]           v_i,
  output logic [1:0]           ready_o,
  output logic [2*width_p-1:0] data_o,
  output logic [1:0]           v_o,
  input  logic [1:0]           yumi_i
);

  lane_sel_t tail_r;

  logic [num_lanes_gp-1:0][width_p-1:0] lane_data;
  logic [num_lanes_gp-1:0]              lane_v, lane_ready, lane_yumi;
  logic                                 pop0, pop1;

  for (genvar k = 0; k < num_lanes_gp; k++) begin : g_lane
    bsg_round_robin_lane_fifo #(
      .width_p (width_p),
      .els_p   (els_p)
    ) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (data_i[k*width_p +: width_p]),
      .v_i       (v_i[k]),
      .ready_o   (lane_ready[k]),
      .data_o    (lane_data[k]),
      .v_o       (lane_v[k]),
      .yumi_i    (lane_yumi[k])
    );
  end

  assign ready_o = lane_ready;

  // Slot 1 is only valid behind a valid slot 0, so a younger element in the
  // other lane is never shown while the older one is still missing.
  assign v_o[0] = lane_v[tail_r];
  assign v_o[1] = lane_v[tail_r] & lane_v[~tail_r];
  assign data_o = {lane_data[~tail_r], lane_data[tail_r]};

  // Only effective pops steer the lanes and the tail, so a malformed yumi
  // cannot skip an element or desynchronise tail_r from the lane contents.
  assign pop0 = yumi_i[0] & v_o[0];
  assign pop1 = pop0 & yumi_i[1] & v_o[1];

  always_comb begin
    lane_yumi          = '0;
    lane_yumi[tail_r]  = pop0;
    lane_yumi[~tail_r] = pop1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) tail_r <= lane0;
    else            tail_r <= tail_r ^ pop0 ^ pop1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i[1] && !yumi_i[0]))
        else $error("yumi_i not thermometer coded: %b", yumi_i);
      for (int k = 0; k < 2; k++) begin
        assert (!(yumi_i[k] && !v_o[k]))
          else $error("yumi_i[%0d] without v_o[%0d]", k, k);
        // Dropped writes are harmless to state, so this only warns.
        assert (!(v_i[k] && !ready_o[k]))
          else $warning("write on lane %0d while not ready is dropped", k);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_round_robin_2_to_2_deswizzle.sv
module tb_bsg_round_robin_2_to_2_deswizzle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_i;
  logic [1:0]  v_i, yumi_i;
  logic [1:0]  ready_o, v_o;
  logic [15:0] data_o;

  logic [15:0] d3_data_i;
  logic [1:0]  d3_v_i, d3_yumi_i;
  logic [1:0]  d3_ready_o, d3_v_o;
  logic [15:0] d3_data_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bsg_round_robin_2_to_2_deswizzle #(.width_p(8), .els_p(4)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(data_i), .v_i(v_i),
    .ready_o(ready_o), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i)
  );

  bsg_round_robin_2_to_2_deswizzle #(.width_p(8), .els_p(3)) dut3 (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(d3_data_i), .v_i(d3_v_i),
    .ready_o(d3_ready_o), .data_o(d3_data_o), .v_o(d3_v_o), .yumi_i(d3_yumi_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic idle();
    v_i = 2'b00; yumi_i = 2'b00; data_i = 16'h0;
  endtask

  initial begin
    int wr, rd, cyc, navail, nr, nw, l;
    logic stop;

    rst_n = 1'b0; idle();
    d3_data_i = 16'h0; d3_v_i = 2'b00; d3_yumi_i = 2'b00;

    // reset
    tick();
    chk("rst_v", v_o, 2'b00);
    chk("rst_ready", ready_o, 2'b00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", ready_o, 2'b11);
    chk("post_rst_v", v_o, 2'b00);

    // both lanes written at one edge
    data_i = 16'hB2A1; v_i = 2'b11;
    tick(); idle();
    chk("pair_v", v_o, 2'b11);
    chk("pair_data", data_o, 16'hB2A1);
    chk("pair_ready", ready_o, 2'b11);

    // single-element reads: lane0 A1,A3 / lane1 B2
    data_i = 16'h00A3; v_i = 2'b01;
    tick(); idle();
    chk("single_pre_data", data_o, 16'hB2A1);
    yumi_i = 2'b01;
    tick();
    chk("single1_v", v_o, 2'b11);
    chk("single1_data", data_o, 16'hA3B2);
    tick();
    chk("single2_v", v_o, 2'b01);
    chk("single2_data", data_o[7:0], 8'hA3);
    tick(); idle();
    chk("single3_v", v_o, 2'b00);

    // imbalance: tail now on lane 1, only lane 0 has data
    data_i = 16'h0055; v_i = 2'b01;
    tick(); idle();
    chk("imbal_v", v_o, 2'b00);
    data_i = 16'h6600; v_i = 2'b10;
    tick(); idle();
    chk("imbal_fill_v", v_o, 2'b11);
    chk("imbal_fill_data", data_o, 16'h5566);
    yumi_i = 2'b11;
    tick(); idle();
    chk("imbal_drain_v", v_o, 2'b00);

    // full lane 0 (tail on lane 1)
    data_i = 16'h2010; v_i = 2'b11;
    tick();
    data_i = 16'h0011; v_i = 2'b01; tick();
    data_i = 16'h0012; tick();
    data_i = 16'h0013; tick();
    idle();
    chk("full_ready", ready_o, 2'b10);
    chk("full_v", v_o, 2'b11);
    chk("full_data", data_o, 16'h1020);
    // fifth write held while full, with a double pop in the same cycle
    data_i = 16'h0099; v_i = 2'b01; yumi_i = 2'b11;
    tick(); idle();
    chk("unfull_ready", ready_o, 2'b11);
    chk("unfull_v", v_o, 2'b00);
    data_i = 16'h2100; v_i = 2'b10;
    tick();
    chk("drain1_data", data_o, 16'h1121);
    data_i = 16'h2200; v_i = 2'b10; yumi_i = 2'b11;
    tick();
    chk("drain2_data", data_o, 16'h1222);
    data_i = 16'h2300;
    tick(); idle();
    chk("drain3_data", data_o, 16'h1323);
    chk("drain3_v", v_o, 2'b11);
    yumi_i = 2'b11;
    tick(); idle();
    chk("no_fifth_v", v_o, 2'b00);
    chk("no_fifth_ready", ready_o, 2'b11);

    // wrap and double pop on the els_p=3 instance
    wr = 0; rd = 0; cyc = 0;
    while (rd < 20 && cyc < 500) begin
      navail = d3_v_o[1] ? 2 : (d3_v_o[0] ? 1 : 0);
      nr = $urandom_range(0, 2);
      if (nr > navail) nr = navail;
      for (int i = 0; i < 2; i++)
        if (i < nr) chk("wrap_data", d3_data_o[i*8 +: 8], rd + i);
      rd += nr;
      d3_yumi_i = (nr == 2) ? 2'b11 : ((nr == 1) ? 2'b01 : 2'b00);
      nw = $urandom_range(0, 2);
      if (wr + nw > 20) nw = 20 - wr;
      d3_v_i = 2'b00; d3_data_i = 16'h0; stop = 1'b0;
      for (int i = 0; i < 2; i++)
        if (i < nw && !stop) begin
          l = wr & 1;
          if (d3_ready_o[l]) begin
            d3_v_i[l] = 1'b1;
            d3_data_i[l*8 +: 8] = wr[7:0];
            wr++;
          end else begin
            stop = 1'b1;
          end
        end
      tick();
      cyc++;
    end
    d3_v_i = 2'b00; d3_yumi_i = 2'b00;
    chk("wrap_all_read", rd, 20);
    tick();
    chk("wrap_empty_v", d3_v_o, 2'b00);

    // reset mid-stream with three stored elements
    data_i = 16'h3130; v_i = 2'b11; tick();
    data_i = 16'h0032; v_i = 2'b01; tick();
    idle();
    rst_n = 1'b0;
    tick();
    chk("midrst_v", v_o, 2'b00);
    chk("midrst_ready", ready_o, 2'b00);
    rst_n = 1'b1;
    tick();
    chk("after_rst_ready", ready_o, 2'b11);
    chk("after_rst_v", v_o, 2'b00);
    data_i = 16'h4241; v_i = 2'b11;
    tick(); idle();
    chk("after_rst_data", data_o, 16'h4241);
    chk("after_rst_pair_v", v_o, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
